wall_height_lfsr: RTL and testbench

Parametrised pseudo-random wall-height source for the side-scrolling game. A configurable-width Fibonacci LFSR is advanced a set number of steps per request, scaled into [MIN_H, MAX_H] and optionally slew-limited against the previous height. The result is handed to the wall/draw logic through a valid/ready handshake. The game FSM raises `req` each time a new wall column is spawned.

---
 rtl/wall_height_lfsr_pkg.sv | 22 ++
 rtl/wall_height_lfsr_if.sv | 23 ++
 rtl/wall_height_lfsr_core.sv | 42 ++++
 rtl/wall_height_lfsr.sv | 145 ++++++++++++++
 tb/tb_wall_height_lfsr.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wall_height_lfsr_pkg.sv
// Shared types and helpers for the wall-height generator and related
// pseudo-random sources.
package wall_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MAP   = 2'd2,
        ST_VALID = 2'd3
    } wall_state_e;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

    // Widest LFSR the zero-lock helper can serve.
    localparam int GUARD_W = 64;

    function automatic logic [GUARD_W-1:0] zero_guard(input logic [GUARD_W-1:0] v);
        return (v == '0) ? GUARD_W'(1) : v;
    endfunction

endpackage

// File: rtl/wall_height_lfsr_if.sv
// Request/seed/result bundle between the game FSM and the height source.
interface wall_height_lfsr_if #(
    parameter int LFSR_W = 16,
    parameter int OUT_W  = 8
);
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              req;
    logic              out_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_height;
    logic              busy;

    modport slave (
        input  seed_load, seed, req, out_ready,
        output out_valid, out_height, busy
    );

    modport master (
        output seed_load, seed, req, out_ready,
        input  out_valid, out_height, busy
    );
endinterface

// File: rtl/wall_height_lfsr_core.sv
// Fibonacci LFSR with load and step enables; never settles in the all-zero
// state because every load or step result passes through the zero guard.
module lfsr_core
    import wall_gen_pkg::*;
#(
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(DEF_SEED)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic              fb;

    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = state_q;
        if (load) begin
            state_d = LFSR_W'(zero_guard(GUARD_W'(load_val)));
        end else if (step) begin
            state_d = LFSR_W'(zero_guard(GUARD_W'({state_q[LFSR_W-2:0], fb})));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= LFSR_W'(zero_guard(GUARD_W'(SEED)));
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/wall_height_lfsr.sv
// Pseudo-random wall-height source: LFSR stepped SHIFTS times per request,
// scaled into [MIN_H, MAX_H], optionally slew-limited, returned by valid/ready.
module wall_height_lfsr
    import wall_gen_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(DEF_SEED),
    parameter int                OUT_W    = 8,
    parameter int                MIN_H    = 20,
    parameter int                MAX_H    = 100,
    parameter int                SHIFTS   = 8,
    parameter int                MAX_STEP = 0,
    parameter bit                FREE_RUN = 1'b1
) (
    input  logic                clock,
    input  logic                resetn,
    wall_height_lfsr_if.slave   bus
);

    localparam int RANGE = MAX_H - MIN_H + 1;
    localparam int PW    = 2 * OUT_W + 1;
    localparam int SW    = OUT_W + 2;
    localparam int CW    = $clog2(SHIFTS + 1);
    localparam logic [OUT_W-1:0] MID_H = OUT_W'((MIN_H + MAX_H) / 2);

    wall_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]  prev_q, prev_d;
    logic [OUT_W-1:0]  height_q, height_d;
    logic              valid_q, valid_d;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_state;

    logic [OUT_W-1:0]    raw;
    logic [OUT_W:0]      scaled;
    logic signed [SW-1:0] s_scaled, s_prev, s_hi, s_lo, s_lim;
    logic [OUT_W-1:0]    height_new;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clock    (clock),
        .resetn   (resetn),
        .load     (bus.seed_load),
        .load_val (bus.seed),
        .step     (lfsr_step),
        .state    (lfsr_state)
    );

    // Height mapping and slew limit, evaluated against the settled LFSR in MAP.
    always_comb begin
        raw      = OUT_W'(lfsr_state >> (LFSR_W - OUT_W));
        scaled   = (OUT_W+1)'(MIN_H) + (OUT_W+1)'((PW'(raw) * PW'(RANGE)) >> OUT_W);
        s_scaled = $signed({1'b0, scaled});
        s_prev   = $signed({2'b00, prev_q});
        s_hi     = s_prev + $signed(SW'(MAX_STEP));
        s_lo     = s_prev - $signed(SW'(MAX_STEP));
        s_lim    = s_scaled;
        if (MAX_STEP > 0) begin
            if (s_scaled > s_hi) begin
                s_lim = s_hi;
            end else if (s_scaled < s_lo) begin
                s_lim = s_lo;
            end
        end
        if (s_lim > $signed(SW'(MAX_H))) begin
            s_lim = $signed(SW'(MAX_H));
        end else if (s_lim < $signed(SW'(MIN_H))) begin
            s_lim = $signed(SW'(MIN_H));
        end
        height_new = s_lim[OUT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        height_d  = height_q;
        valid_d   = valid_q;
        lfsr_step = 1'b0;

        if (bus.seed_load) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            prev_d  = MID_H;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    lfsr_step = FREE_RUN;
                    if (bus.req) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                // SHIFTS stepping cycles plus one terminal cycle before MAP.
                ST_SHIFT: begin
                    if (cnt_q < CW'(SHIFTS)) begin
                        lfsr_step = 1'b1;
                        cnt_d     = cnt_q + CW'(1);
                    end else begin
                        state_d = ST_MAP;
                    end
                end
                ST_MAP: begin
                    height_d = height_new;
                    valid_d  = 1'b1;
                    state_d  = ST_VALID;
                end
                ST_VALID: begin
                    if (bus.out_ready) begin
                        valid_d = 1'b0;
                        prev_d  = height_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prev_q   <= MID_H;
            height_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            height_q <= height_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_height = height_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wall_height_lfsr.sv
// Randomized self-checking bench: three configurations share one stimulus
// stream and are compared against a behavioural model; plus an LFSR period run.
module tb_wall_height_lfsr;

    localparam int           SHIFTS = 8;
    localparam logic [15:0]  M_TAPS = 16'hB400;
    localparam logic [15:0]  M_SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        out_ready = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic        per_step = 1'b0;
    logic [15:0] per_state;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_prev_slew;
    logic [15:0] m_lfsr;

    always #5 clock = ~clock;

    wall_height_lfsr_if #(.LFSR_W(16), .OUT_W(8)) if_main ();
    wall_height_lfsr_if #(.LFSR_W(16), .OUT_W(8)) if_slew ();
    wall_height_lfsr_if #(.LFSR_W(16), .OUT_W(8)) if_flat ();

    assign if_main.req = req;       assign if_slew.req = req;       assign if_flat.req = req;
    assign if_main.out_ready = out_ready; assign if_slew.out_ready = out_ready; assign if_flat.out_ready = out_ready;
    assign if_main.seed_load = seed_load; assign if_slew.seed_load = seed_load; assign if_flat.seed_load = seed_load;
    assign if_main.seed = seed;     assign if_slew.seed = seed;     assign if_flat.seed = seed;

    wall_height_lfsr #(.FREE_RUN(1'b0)) u_main (
        .clock(clock), .resetn(resetn), .bus(if_main)
    );
    wall_height_lfsr #(.MAX_STEP(5), .FREE_RUN(1'b0)) u_slew (
        .clock(clock), .resetn(resetn), .bus(if_slew)
    );
    wall_height_lfsr #(.MIN_H(50), .MAX_H(50), .FREE_RUN(1'b1)) u_flat (
        .clock(clock), .resetn(resetn), .bus(if_flat)
    );

    lfsr_core #(.LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1)) u_per (
        .clock(clock), .resetn(resetn), .load(1'b0), .load_val(16'h0000),
        .step(per_step), .state(per_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] m_advance(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = {v[14:0], ^(v & M_TAPS)};
            if (v == 16'h0) v = 16'h1;
        end
        return v;
    endfunction

    function automatic int m_map(input logic [15:0] s, input int lo, input int hi);
        int top8;
        top8 = int'(s) / 256;
        return lo + (top8 * (hi - lo + 1)) / 256;
    endfunction

    function automatic int m_slew(input int sc, input int prev, input int ms, input int lo, input int hi);
        int r;
        r = sc;
        if (ms > 0) begin
            if (sc > prev + ms)      r = prev + ms;
            else if (sc < prev - ms) r = prev - ms;
        end
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic seed_cmd(input logic [15:0] s);
        seed      = s;
        seed_load = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        m_lfsr      = (s == 16'h0) ? 16'h1 : s;
        m_prev_slew = 60;
    endtask

    task automatic run_req(input int ready_wait, input bit poke_req);
        int cyc;
        bit seen;
        bit held;
        int sc, exp_main, exp_slew;
        m_lfsr   = m_advance(m_lfsr, SHIFTS);
        sc       = m_map(m_lfsr, 20, 100);
        exp_main = m_slew(sc, m_prev_slew, 0, 20, 100);
        exp_slew = m_slew(sc, m_prev_slew, 5, 20, 100);

        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        chk("busy_in_shift", 32'(if_main.busy), 1);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (if_main.out_valid) seen = 1'b1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("latency", 32'(cyc - 1), SHIFTS + 2);
        chk("height_main", 32'(if_main.out_height), 32'(exp_main));
        chk("height_slew", 32'(if_slew.out_height), 32'(exp_slew));
        chk("height_flat", 32'(if_flat.out_height), 50);
        chk("valid_flat", 32'(if_flat.out_valid), 1);

        if (ready_wait > 0) begin
            held = 1'b1;
            for (int i = 0; i < ready_wait; i++) begin
                req = (poke_req && i == 2);
                @(negedge clock);
                if (if_main.out_height !== 8'(exp_main) || !if_main.out_valid) held = 1'b0;
            end
            req = 1'b0;
            chk("hold_stable", 32'(held), 1);
            chk("busy_in_valid", 32'(if_main.busy), 1);
        end

        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("valid_drop", 32'(if_main.out_valid), 0);
        chk("idle_after_hs", 32'(if_slew.busy), 0);
        m_prev_slew = exp_slew;
    endtask

    task automatic abort_mid_shift(input logic [15:0] ns);
        bit bad;
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        repeat (3) @(negedge clock);
        seed      = ns;
        seed_load = 1'b1;
        req       = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        req       = 1'b0;
        m_lfsr      = (ns == 16'h0) ? 16'h1 : ns;
        m_prev_slew = 60;
        chk("abort_busy", 32'(if_main.busy), 0);
        bad = 1'b0;
        repeat (SHIFTS + 6) begin
            @(negedge clock);
            if (if_main.out_valid || if_slew.out_valid) bad = 1'b1;
        end
        chk("abort_no_valid", 32'(bad), 0);
    endtask

    task automatic period_check();
        int cnt;
        @(negedge clock);
        per_step = 1'b1;
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (per_state !== M_SEED && cnt < 70000);
        per_step = 1'b0;
        chk("lfsr_period", 32'(cnt), 65535);
    endtask

    task automatic find_seed(input int want, output logic [15:0] s);
        logic [15:0] cand;
        s = 16'h0001;
        for (int i = 0; i < 200000; i++) begin
            cand = 16'($urandom);
            if (cand != 16'h0 && m_map(m_advance(cand, SHIFTS), 20, 100) == want) begin
                s = cand;
                break;
            end
        end
    endtask

    task automatic main_tests();
        logic [15:0] s;
        // Zero seed loads as 1.
        seed_cmd(16'h0000);
        chk("zero_seed_lfsr", 32'(u_main.u_lfsr.state), 1);
        run_req(0, 1'b0);

        // Slew limit against prev = 60.
        find_seed(100, s);
        seed_cmd(s);
        run_req(0, 1'b0);
        chk("slew_up", 32'(if_slew.out_height), 65);
        find_seed(20, s);
        seed_cmd(s);
        run_req(0, 1'b0);
        chk("slew_down", 32'(if_slew.out_height), 55);

        // Consumer stall with an ignored req pulse.
        run_req(20, 1'b1);

        abort_mid_shift(16'($urandom));
        run_req(1, 1'b0);

        for (int i = 0; i < 95; i++) begin
            if ($urandom_range(0, 5) == 0) seed_cmd(16'($urandom));
            run_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        m_lfsr      = M_SEED;
        m_prev_slew = 60;
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(if_main.out_valid), 0);
        chk("rst_height", 32'(if_main.out_height), 0);
        chk("rst_busy", 32'(if_main.busy), 0);
        chk("rst_lfsr", 32'(u_main.u_lfsr.state), 32'(M_SEED));
        resetn = 1'b1;
        @(negedge clock);
        fork
            period_check();
            main_tests();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
